// File: rtl/matrix_mac_engine.sv
// matrix_mac_engine: sequential NxN unsigned matrix multiply, one MAC per cycle; define MATRIX_SATURATE_EN to saturate results instead of wrapping
module matrix_mac_engine #(
   parameter int N  = 2,
   parameter int DW = 16,
   parameter int RW = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N*N*DW-1:0] flat_matrix_1,
   input  logic [N*N*DW-1:0] flat_matrix_2,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N*N*RW-1:0] res_mat
);
   localparam int AW = 2*DW + $clog2(N);
   localparam int EW = AW > RW ? AW : RW;
   localparam int CW = $clog2(N);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t              state_q, state_d;
   logic [N*N*DW-1:0]   a_q, a_d, b_q, b_d;
   logic [CW-1:0]       i_q, i_d, j_q, j_d, k_q, k_d;
   logic [AW-1:0]       acc_q, acc_d, mac;
   logic [N*N*RW-1:0]   buf_q, buf_d, res_q, res_d;
   logic [2*DW-1:0]     prod;
   int                  ai, bi, ci;
   function automatic logic [RW-1:0] reduce(input logic [AW-1:0] v);
`ifdef MATRIX_SATURATE_EN
      return (EW'(v) >> RW) != '0 ? '1 : RW'(v);
`else
      return RW'(v);
`endif
   endfunction
   assign in_ready  = state_q == IDLE;
   assign out_valid = state_q == DONE;
   assign res_mat   = res_q;
   // next state: operand capture, k/j/i-ordered MAC walk, result publish on the final product
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      i_d     = i_q;
      j_d     = j_q;
      k_d     = k_q;
      acc_d   = acc_q;
      buf_d   = buf_q;
      res_d   = res_q;
      ai      = (N*N-1-(int'(i_q)*N+int'(k_q)))*DW;
      bi      = (N*N-1-(int'(k_q)*N+int'(j_q)))*DW;
      ci      = (N*N-1-(int'(i_q)*N+int'(j_q)))*RW;
      prod    = a_q[ai +: DW] * b_q[bi +: DW];
      mac     = acc_q + AW'(prod);
      case (state_q)
         IDLE: if (in_valid) begin
            state_d = CALC;
            a_d     = flat_matrix_1;
            b_d     = flat_matrix_2;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            acc_d   = '0;
         end
         CALC: if (k_q == CW'(N-1)) begin
            acc_d            = '0;
            k_d              = '0;
            buf_d[ci +: RW]  = reduce(mac);
            if (j_q == CW'(N-1)) begin
               j_d = '0;
               if (i_q == CW'(N-1)) begin
                  state_d = DONE;
                  res_d   = buf_d;
               end else begin
                  i_d = i_q + 1'b1;
               end
            end else begin
               j_d = j_q + 1'b1;
            end
         end else begin
            acc_d = mac;
            k_d   = k_q + 1'b1;
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // state and datapath registers, cleared asynchronously so a reset abandons any job
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         acc_q   <= '0;
         buf_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         acc_q   <= acc_d;
         buf_q   <= buf_d;
         res_q   <= res_d;
      end
   end
endmodule

// File: tb/tb_matrix_mac_engine.sv
// tb_matrix_mac_engine: scoreboard bench for matrix_mac_engine (N=2 and N=3 instances)
module tb_matrix_mac_engine;
   logic         clk = 0, rst = 1;
   logic         iv = 0, ordy = 1, ir, ov;
   logic [63:0]  a = '0, b = '0, res;
   logic         iv3 = 0, ir3, ov3;
   logic [143:0] a3 = '0, b3 = '0, res3;
   logic [159:0] q[$];
   logic [159:0] last_res = '0;
   int           n_cmp = 0, n_err = 0;
   always #5 clk = ~clk;
   matrix_mac_engine #(.N(2), .DW(16), .RW(16)) u_dut (
      .CLK(clk), .RST(rst), .in_valid(iv), .in_ready(ir),
      .flat_matrix_1(a), .flat_matrix_2(b),
      .out_valid(ov), .out_ready(ordy), .res_mat(res));
   matrix_mac_engine #(.N(3), .DW(16), .RW(16)) u_dut3 (
      .CLK(clk), .RST(rst), .in_valid(iv3), .in_ready(ir3),
      .flat_matrix_1(a3), .flat_matrix_2(b3),
      .out_valid(ov3), .out_ready(1'b1), .res_mat(res3));
   task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   function automatic logic [159:0] model(input int n, input logic [255:0] x, input logic [255:0] y);
      logic [159:0] r = '0;
      longint s;
      for (int i = 0; i < n; i++)
         for (int j = 0; j < n; j++) begin
            s = 0;
            for (int k = 0; k < n; k++)
               s += longint'(x[(n*n-1-(i*n+k))*16 +: 16]) * longint'(y[(n*n-1-(k*n+j))*16 +: 16]);
`ifdef MATRIX_SATURATE_EN
            r[(n*n-1-(i*n+j))*16 +: 16] = s > 65535 ? 16'hFFFF : s[15:0];
`else
            r[(n*n-1-(i*n+j))*16 +: 16] = s[15:0];
`endif
         end
      return r;
   endfunction
   // scoreboard: every handshake of the N=2 instance pops one expected result
   always @(negedge clk) begin
      if (!rst && ov && ordy) begin
         if (q.size() == 0) check("spurious_out", 1, 0);
         else begin
            last_res = q.pop_front();
            check("res_mat", 160'(res), last_res);
         end
      end
   end
   task automatic accept(input logic [63:0] x, input logic [63:0] y);
      int t = 0;
      while (!ir && t < 200) begin @(posedge clk); #1; t++; end
      check("in_ready_wait", 160'(ir), 1);
      iv = 1; a = x; b = y;
      q.push_back(model(2, 256'(x), 256'(y)));
      @(posedge clk); #1;
      iv = 0;
   endtask
   task automatic wait_done(input string tag, input int lat);
      int cnt = 0;
      while (cnt < 200) begin
         @(posedge clk); #1; cnt++;
         if (ov) break;
         check({tag, "_stable"}, 160'(res), last_res);
      end
      check({tag, "_latency"}, cnt, lat);
   endtask
   initial begin
      int cnt;
      #12;
      check("rst_in_ready", 160'(ir), 1);
      check("rst_out_valid", 160'(ov), 0);
      check("rst_res", 160'(res), 0);
      rst = 0;
      @(posedge clk); #1;
      accept({16'd1, 16'd2, 16'd3, 16'd4}, {16'd5, 16'd6, 16'd7, 16'd8});
      check("busy_in_ready", 160'(ir), 0);
      wait_done("basic", 8);
      check("basic_value", 160'(res), 160'({16'd19, 16'd22, 16'd43, 16'd50}));
      @(posedge clk); #1;
      check("basic_pulse", 160'(ov), 0);
      accept({4{16'hFFFF}}, {4{16'hFFFF}});
      wait_done("max", 8);
      @(posedge clk); #1;
      ordy = 0;
      accept({16'd1, 16'd1, 16'd1, 16'd1}, {16'd2, 16'd3, 16'd4, 16'd5});
      wait_done("hold", 8);
      iv = 1; a = {4{16'd9}}; b = {4{16'd9}};
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check("hold_valid", 160'(ov), 1);
         check("hold_ready", 160'(ir), 0);
         check("hold_res", 160'(res), 160'({16'd6, 16'd8, 16'd6, 16'd8}));
      end
      iv = 0; ordy = 1;
      @(posedge clk); #1;
      check("drain_valid", 160'(ov), 0);
      check("drain_ready", 160'(ir), 1);
      repeat (3) @(posedge clk);
      #1 check("no_accept", 160'(ir), 1);
      accept({16'd1, 16'd2, 16'd3, 16'd4}, {16'd5, 16'd6, 16'd7, 16'd8});
      repeat (3) @(posedge clk);
      #1 rst = 1;
      q.delete();
      last_res = '0;
      @(posedge clk); #1;
      check("abort_res", 160'(res), 0);
      check("abort_valid", 160'(ov), 0);
      check("abort_ready", 160'(ir), 1);
      rst = 0;
      repeat (10) @(posedge clk);
      #1 check("abort_quiet", 160'(ov), 0);
      accept({16'd2, 16'd0, 16'd0, 16'd2}, {16'd3, 16'd1, 16'd4, 16'd1});
      wait_done("post_abort", 8);
      check("post_abort_value", 160'(res), 160'({16'd6, 16'd2, 16'd8, 16'd2}));
      @(posedge clk); #1;
      iv3 = 1;
      a3 = {16'd1, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd1};
      b3 = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
      @(posedge clk); #1;
      iv3 = 0;
      cnt = 0;
      while (cnt < 200) begin
         @(posedge clk); #1; cnt++;
         if (ov3) break;
      end
      check("n3_latency", cnt, 27);
      check("n3_value", 160'(res3), model(3, 256'(a3), 256'(b3)));
      check("n3_identity", 160'(res3), 160'(b3));
      @(posedge clk); #1;
      check("scoreboard_empty", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
